match_sequencer: RTL and testbench
==================================

# match_sequencer

Sequencing controller for the brute-force string matcher. It walks a pattern memory and a text memory, both synchronous-read ROMs with one cycle of read latency, through every alignment of the pattern against the text. It compares one character pair per step, counts complete (possibly overlapping) occurrences and records the first match position. It replaces ad-hoc counter/comparator wiring with one start/busy/done handshake that the top level or a host FSM drives.

## Interface
Parameters:
- TEXT_LEN, 56, number of characters in the text ROM (addresses 0..TEXT_LEN-1)
- PAT_LEN, 4, number of characters in the pattern ROM (addresses 0..PAT_LEN-1)
- TAW, 8, text address width
- PAW, 3, pattern address width
- CW, 8, width of the match counter and first-position result

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  reset, synchronous and active-low
- start  in  1  one-cycle request to begin a search; ignored unless the block is idle
- pat_addr  out  PAW  pattern ROM address, registered
- pat_data  in  8  pattern ROM data, valid the cycle after pat_addr is presented
- txt_addr  out  TAW  text ROM address, registered
- txt_data  in  8  text ROM data, valid the cycle after txt_addr is presented
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the search ends
- count  out  CW  number of complete matches, saturating at 2^CW-1
- found  out  1  at least one match in the last search
- first_pos  out  CW  text index of the first match; 0 when found=0

## Operation
- Internal registers: base (alignment, TAW bits), idx (pattern index, PAW bits), and state.
- States and transitions:
  - IDLE: on start, go to FETCH. Clear count, found and first_pos. Set base=0, idx=0.
  - FETCH: addresses are stable; the ROMs sample them. Always go to CMP.
  - CMP: compare txt_data with pat_data.
    - Equal and idx<PAT_LEN-1: idx+1, go to FETCH.
    - Equal and idx=PAT_LEN-1: a match. Increment count (saturating). If found=0, set found=1 and first_pos=base. Advance base.
    - Mismatch: advance base.
  - Advance base: if base=TEXT_LEN-PAT_LEN, go to DONE. Otherwise base+1, idx=0, go to FETCH.
  - DONE: done=1 for one cycle, then go to IDLE.
- Address outputs: txt_addr=base+idx and pat_addr=idx. Both are registered and update with base and idx.
- Matches may overlap because base always advances by 1.
- If PAT_LEN>TEXT_LEN, a start goes straight to DONE with count=0 and found=0. No ROM reads occur.
- Results (count, found, first_pos) hold their values from DONE until the next accepted start.
- start while busy is ignored. It is neither queued nor a restart.

## Timing
- Reset (rst=0 at an edge) values: IDLE, busy=0, done=0, count=0, found=0, first_pos=0, pat_addr=0, txt_addr=0. Reset mid-search aborts immediately and discards partial results.
- Each character comparison costs 2 cycles (FETCH, CMP).
- Latency: if start is sampled at edge 0, busy=1 from edge 1. done rises 1 cycle after the final CMP. Total edge-0-to-done latency = 2×(characters compared)+1.
- Example: text with no first-character hit, TEXT_LEN=56, PAT_LEN=4. That is 53 alignments, so done rises at edge 107. busy falls in the same cycle done is high.
- Minimum start-to-start spacing: the cycle after done.

## Configuration
- FIRST_MATCH_STOP_EN, when defined: the search ends at the first complete match. From that CMP the block goes to DONE, so count is at most 1. first_pos is as above.
- Without the macro: all alignments are scanned and every match is counted.

## Test plan
- Pattern "HOLA", text containing "HOLA" at indices 0 and 20, otherwise 'x' → count=2, found=1, first_pos=0. done is one cycle wide and busy is low after it.
- Pattern "AAAA", text of 10 'A' then 'x' to the end → count=7 (overlapping matches), first_pos=0.
- Pattern "HOLA", text with no 'H' → count=0, found=0, first_pos=0. done rises exactly 107 edges after start.
- Pattern matching only the last alignment (index 52) → count=1, first_pos=52. txt_addr reaches 55 and never exceeds it.
- start pulsed mid-search → no effect on the result. rst=0 mid-search → all outputs at reset values the next cycle, and a new start runs cleanly.
- With FIRST_MATCH_STOP_EN: the first test's stimulus gives count=1 and first_pos=0. done rises 2×4+1=9 edges after start.

Source files
------------

// File: rtl/match_sequencer.sv
// -----------------------------------------------------------------------------
// match_sequencer
//
// Sequencing controller for a brute-force string matcher. It walks a pattern
// ROM and a text ROM (both synchronous read, one cycle of latency) through
// every alignment of the pattern against the text. It compares one character
// pair per FETCH/CMP step and counts complete, possibly overlapping,
// occurrences. It also records the text index of the first occurrence.
//
// Optional feature macro:
//   FIRST_MATCH_STOP_EN - when defined, the search ends at the first complete
//                         match, so count never exceeds 1.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-low reset
//   start      in   one-cycle search request, honoured only when idle
//   pat_addr   out  pattern ROM address (registered)
//   pat_data   in   pattern ROM data, valid the cycle after pat_addr
//   txt_addr   out  text ROM address (registered)
//   txt_data   in   text ROM data, valid the cycle after txt_addr
//   busy       out  search in progress
//   done       out  one-cycle pulse at the end of a search
//   count      out  number of complete matches (saturating)
//   found      out  at least one match in the last search
//   first_pos  out  text index of the first match, 0 when none
// -----------------------------------------------------------------------------
module match_sequencer #(
    parameter int TEXT_LEN = 56,
    parameter int PAT_LEN  = 4,
    parameter int TAW      = 8,
    parameter int PAW      = 3,
    parameter int CW       = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [PAW-1:0] pat_addr,
    input  logic [7:0]     pat_data,
    output logic [TAW-1:0] txt_addr,
    input  logic [7:0]     txt_data,
    output logic           busy,
    output logic           done,
    output logic [CW-1:0]  count,
    output logic           found,
    output logic [CW-1:0]  first_pos
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CMP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A pattern longer than the text has no alignment at all.
    localparam bit             NO_ALIGN    = (PAT_LEN > TEXT_LEN);
    localparam int             LAST_BASE_I = NO_ALIGN ? 0 : (TEXT_LEN - PAT_LEN);
    localparam logic [TAW-1:0] LAST_BASE   = LAST_BASE_I[TAW-1:0];
    localparam int             LAST_IDX_I  = (PAT_LEN > 0) ? (PAT_LEN - 1) : 0;
    localparam logic [PAW-1:0] LAST_IDX    = LAST_IDX_I[PAW-1:0];
    localparam logic [CW-1:0]  COUNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0]  CW_ONE      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [TAW-1:0] TAW_ONE     = {{(TAW-1){1'b0}}, 1'b1};
    localparam logic [PAW-1:0] PAW_ONE     = {{(PAW-1){1'b0}}, 1'b1};

`ifdef FIRST_MATCH_STOP_EN
    localparam bit STOP_ON_MATCH = 1'b1;
`else
    localparam bit STOP_ON_MATCH = 1'b0;
`endif

    state_t         state_r,     state_s;
    logic [TAW-1:0] base_r,      base_s;
    logic [PAW-1:0] idx_r,       idx_s;
    logic [CW-1:0]  count_r,     count_s;
    logic           found_r,     found_s;
    logic [CW-1:0]  first_pos_r, first_pos_s;
    logic [PAW-1:0] pat_addr_r;
    logic [TAW-1:0] txt_addr_r,  txt_addr_s;
    logic           busy_r,      busy_s;
    logic           done_r,      done_s;

    logic           char_eq_s;
    logic           last_idx_s;
    logic           last_base_s;
    logic           full_match_s;

    assign char_eq_s    = (txt_data == pat_data);
    assign last_idx_s   = (idx_r == LAST_IDX);
    assign last_base_s  = (base_r == LAST_BASE);
    assign full_match_s = char_eq_s && last_idx_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (NO_ALIGN) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_CMP;
            end
            ST_CMP: begin
                if (char_eq_s && !last_idx_s) begin
                    state_s = ST_FETCH;
                end else if (full_match_s && STOP_ON_MATCH) begin
                    state_s = ST_DONE;
                end else if (last_base_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: alignment, pattern index and search results.
    always_comb begin
        base_s      = base_r;
        idx_s       = idx_r;
        count_s     = count_r;
        found_s     = found_r;
        first_pos_s = first_pos_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    base_s      = {TAW{1'b0}};
                    idx_s       = {PAW{1'b0}};
                    count_s     = {CW{1'b0}};
                    found_s     = 1'b0;
                    first_pos_s = {CW{1'b0}};
                end else begin
                    base_s = base_r;
                end
            end
            ST_CMP: begin
                if (char_eq_s && !last_idx_s) begin
                    idx_s = idx_r + PAW_ONE;
                end else begin
                    if (full_match_s) begin
                        if (count_r != COUNT_MAX) begin
                            count_s = count_r + CW_ONE;
                        end else begin
                            count_s = count_r;
                        end
                        if (!found_r) begin
                            found_s     = 1'b1;
                            first_pos_s = CW'(base_r);
                        end else begin
                            found_s = found_r;
                        end
                    end else begin
                        count_s = count_r;
                    end
                    // On the way to DONE base/idx hold, so the addresses never
                    // run past the last alignment.
                    if (!(full_match_s && STOP_ON_MATCH) && !last_base_s) begin
                        base_s = base_r + TAW_ONE;
                        idx_s  = {PAW{1'b0}};
                    end else begin
                        base_s = base_r;
                    end
                end
            end
            default: begin
                base_s = base_r;
            end
        endcase
    end

    // Address generation: the registered addresses follow base and idx.
    always_comb begin
        txt_addr_s = base_s + TAW'(idx_s);
    end

    // Status outputs derived from the current state; registered below, so
    // they appear one cycle after the state is entered.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            ST_FETCH: busy_s = 1'b1;
            ST_CMP:   busy_s = 1'b1;
            ST_DONE:  done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Datapath, address and status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            base_r      <= {TAW{1'b0}};
            idx_r       <= {PAW{1'b0}};
            count_r     <= {CW{1'b0}};
            found_r     <= 1'b0;
            first_pos_r <= {CW{1'b0}};
            pat_addr_r  <= {PAW{1'b0}};
            txt_addr_r  <= {TAW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            base_r      <= base_s;
            idx_r       <= idx_s;
            count_r     <= count_s;
            found_r     <= found_s;
            first_pos_r <= first_pos_s;
            pat_addr_r  <= idx_s;
            txt_addr_r  <= txt_addr_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign pat_addr  = pat_addr_r;
    assign txt_addr  = txt_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign count     = count_r;
    assign found     = found_r;
    assign first_pos = first_pos_r;

endmodule

// File: tb/tb_match_sequencer.sv
// -----------------------------------------------------------------------------
// tb_match_sequencer
//
// Self-checking bench for match_sequencer. Two synchronous-read ROM models
// feed the DUT. A reference model scans the same ROM contents at the
// string level and predicts the match count, first position and the number of
// character comparisons, which gives the start-to-done latency.
// -----------------------------------------------------------------------------
module tb_match_sequencer;

    localparam int TEXT_LEN = 56;
    localparam int PAT_LEN  = 4;
    localparam int TAW      = 8;
    localparam int PAW      = 3;
    localparam int CW       = 8;
    localparam int LIMIT    = 4000;

`ifdef FIRST_MATCH_STOP_EN
    localparam int HOLA_CNT = 1;
    localparam int HOLA_LAT = 9;
    localparam int OVL_CNT  = 1;
`else
    localparam int HOLA_CNT = 2;
    localparam int HOLA_LAT = 119;
    localparam int OVL_CNT  = 7;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [PAW-1:0] pat_addr;
    logic [7:0]     pat_data;
    logic [TAW-1:0] txt_addr;
    logic [7:0]     txt_data;
    logic           busy;
    logic           done;
    logic [CW-1:0]  count;
    logic           found;
    logic [CW-1:0]  first_pos;

    logic [7:0] pat_mem [0:(1<<PAW)-1];
    logic [7:0] txt_mem [0:(1<<TAW)-1];

    int n_vec = 0;
    int n_err = 0;

    // observations of the most recent search
    int            obs_edges;
    int            obs_max_addr;
    bit            obs_busy_ok;
    logic          obs_busy_at_done;
    logic          obs_done_after;
    logic [CW-1:0] obs_count;
    logic          obs_found;
    logic [CW-1:0] obs_fpos;

    // reference model results
    int exp_count;
    int exp_found;
    int exp_fpos;
    int exp_lat;

    match_sequencer #(
        .TEXT_LEN(TEXT_LEN), .PAT_LEN(PAT_LEN), .TAW(TAW), .PAW(PAW), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .pat_addr(pat_addr), .pat_data(pat_data),
        .txt_addr(txt_addr), .txt_data(txt_data),
        .busy(busy), .done(done), .count(count),
        .found(found), .first_pos(first_pos)
    );

    always #5 clk = ~clk;

    // synchronous-read ROMs with one cycle of latency
    always @(posedge clk) begin
        pat_data <= pat_mem[pat_addr];
        txt_data <= txt_mem[txt_addr];
    end

    task automatic set_pat(input string s);
        for (int k = 0; k < PAT_LEN; k++) pat_mem[k] = s[k];
    endtask

    task automatic fill_text(input byte c);
        for (int k = 0; k < (1<<TAW); k++) txt_mem[k] = c;
    endtask

    task automatic place(input int pos, input string s);
        for (int k = 0; k < s.len(); k++) txt_mem[pos + k] = s[k];
    endtask

    task automatic random_ab();
        for (int k = 0; k < TEXT_LEN; k++) txt_mem[k] = 8'h41 + 8'($urandom_range(0, 1));
        for (int k = 0; k < PAT_LEN; k++)  pat_mem[k] = 8'h41 + 8'($urandom_range(0, 1));
    endtask

    // String-level scan: every alignment, character by character until the
    // first difference; each character looked at costs two cycles.
    task automatic model_search();
        int c;
        int f;
        int fp;
        int ch;
        int k;
        bit stop;
        c = 0; f = 0; fp = 0; ch = 0; stop = 1'b0;
        for (int b = 0; b + PAT_LEN <= TEXT_LEN && !stop; b++) begin
            k = 0;
            while (k < PAT_LEN) begin
                ch++;
                if (txt_mem[b + k] != pat_mem[k]) break;
                k++;
            end
            if (k == PAT_LEN) begin
                if (c < (1 << CW) - 1) c++;
                if (f == 0) begin
                    f  = 1;
                    fp = b;
                end
`ifdef FIRST_MATCH_STOP_EN
                stop = 1'b1;
`endif
            end
        end
        exp_count = c;
        exp_found = f;
        exp_fpos  = fp;
        exp_lat   = 2 * ch + 1;
    endtask

    // Issue one start and follow the search to its done pulse. Optionally
    // pulses start again pulse_at edges into the search.
    task automatic run_search(input int pulse_at);
        obs_busy_ok  = 1'b1;
        obs_max_addr = 0;
        obs_edges    = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (busy !== 1'b0) obs_busy_ok = 1'b0;
        while (1'b1) begin
            @(posedge clk);
            obs_edges++;
            #1;
            if (int'(txt_addr) > obs_max_addr) obs_max_addr = int'(txt_addr);
            if (done === 1'b1) break;
            if (busy !== 1'b1) obs_busy_ok = 1'b0;
            if (obs_edges == pulse_at) start = 1'b1;
            else start = 1'b0;
            if (obs_edges >= LIMIT) break;
        end
        start            = 1'b0;
        obs_busy_at_done = busy;
        obs_count        = count;
        obs_found        = found;
        obs_fpos         = first_pos;
        @(posedge clk);
        #1;
        obs_done_after = done;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
        n_vec++; if (count !== 8'd0 || found !== 1'b0 || first_pos !== 8'd0) begin
            n_err++; $display("FAIL reset_results got %0d/%b/%0d exp 0/0/0", count, found, first_pos); end
        n_vec++; if (pat_addr !== 3'd0 || txt_addr !== 8'd0) begin
            n_err++; $display("FAIL reset_addr got %0d/%0d exp 0/0", pat_addr, txt_addr); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_hola();
        fill_text("x");
        set_pat("HOLA");
        place(0, "HOLA");
        place(20, "HOLA");
        run_search(0);
        n_vec++; if (obs_count !== CW'(HOLA_CNT)) begin n_err++; $display("FAIL hola_count got %0d exp %0d", obs_count, HOLA_CNT); end
        n_vec++; if (obs_found !== 1'b1) begin n_err++; $display("FAIL hola_found got %b exp 1", obs_found); end
        n_vec++; if (obs_fpos !== 8'd0) begin n_err++; $display("FAIL hola_first_pos got %0d exp 0", obs_fpos); end
        n_vec++; if (obs_edges != HOLA_LAT) begin n_err++; $display("FAIL hola_latency got %0d exp %0d", obs_edges, HOLA_LAT); end
        n_vec++; if (obs_done_after !== 1'b0) begin n_err++; $display("FAIL hola_done_width got %b exp 0", obs_done_after); end
        n_vec++; if (obs_busy_at_done !== 1'b0) begin n_err++; $display("FAIL hola_busy_at_done got %b exp 0", obs_busy_at_done); end
        n_vec++; if (!obs_busy_ok) begin n_err++; $display("FAIL hola_busy_window got 0 exp 1"); end
    endtask

    task automatic test_overlap();
        fill_text("x");
        set_pat("AAAA");
        place(0, "AAAAAAAAAA");
        model_search();
        run_search(0);
        n_vec++; if (obs_count !== CW'(OVL_CNT)) begin n_err++; $display("FAIL overlap_count got %0d exp %0d", obs_count, OVL_CNT); end
        n_vec++; if (obs_fpos !== 8'd0 || obs_found !== 1'b1) begin
            n_err++; $display("FAIL overlap_first got %0d/%b exp 0/1", obs_fpos, obs_found); end
        n_vec++; if (obs_edges != exp_lat) begin n_err++; $display("FAIL overlap_latency got %0d exp %0d", obs_edges, exp_lat); end
    endtask

    task automatic test_no_hit();
        fill_text("x");
        set_pat("HOLA");
        run_search(0);
        n_vec++; if (obs_count !== 8'd0 || obs_found !== 1'b0) begin
            n_err++; $display("FAIL nohit_result got %0d/%b exp 0/0", obs_count, obs_found); end
        n_vec++; if (obs_fpos !== 8'd0) begin n_err++; $display("FAIL nohit_first_pos got %0d exp 0", obs_fpos); end
        n_vec++; if (obs_edges != 107) begin n_err++; $display("FAIL nohit_latency got %0d exp 107", obs_edges); end
    endtask

    task automatic test_last_alignment();
        fill_text("x");
        set_pat("HOLA");
        place(52, "HOLA");
        model_search();
        run_search(0);
        n_vec++; if (obs_count !== 8'd1 || obs_found !== 1'b1) begin
            n_err++; $display("FAIL last_count got %0d/%b exp 1/1", obs_count, obs_found); end
        n_vec++; if (obs_fpos !== 8'd52) begin n_err++; $display("FAIL last_first_pos got %0d exp 52", obs_fpos); end
        n_vec++; if (obs_max_addr != 55) begin n_err++; $display("FAIL last_max_txt_addr got %0d exp 55", obs_max_addr); end
        n_vec++; if (obs_edges != exp_lat) begin n_err++; $display("FAIL last_latency got %0d exp %0d", obs_edges, exp_lat); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            random_ab();
            model_search();
            run_search(0);
            n_vec++; if (obs_count !== CW'(exp_count)) begin n_err++; $display("FAIL rand%0d_count got %0d exp %0d", it, obs_count, exp_count); end
            n_vec++; if (obs_found !== exp_found[0]) begin n_err++; $display("FAIL rand%0d_found got %b exp %0d", it, obs_found, exp_found); end
            n_vec++; if (obs_fpos !== CW'(exp_fpos)) begin n_err++; $display("FAIL rand%0d_first_pos got %0d exp %0d", it, obs_fpos, exp_fpos); end
            n_vec++; if (obs_edges != exp_lat) begin n_err++; $display("FAIL rand%0d_latency got %0d exp %0d", it, obs_edges, exp_lat); end
            n_vec++; if (obs_max_addr > TEXT_LEN - 1) begin n_err++; $display("FAIL rand%0d_addr_range got %0d exp <=55", it, obs_max_addr); end
        end
    endtask

    task automatic test_start_while_busy();
        int pulses [2];
        pulses[0] = 3;
        for (int it = 0; it < 2; it++) begin
            random_ab();
            model_search();
            pulses[1] = exp_lat - 2;
            run_search(pulses[it]);
            n_vec++; if (obs_count !== CW'(exp_count) || obs_fpos !== CW'(exp_fpos)) begin
                n_err++; $display("FAIL busy_start%0d_result got %0d/%0d exp %0d/%0d", it, obs_count, obs_fpos, exp_count, exp_fpos); end
            n_vec++; if (obs_edges != exp_lat) begin n_err++; $display("FAIL busy_start%0d_latency got %0d exp %0d", it, obs_edges, exp_lat); end
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_start%0d_no_restart got %b exp 0", it, busy); end
        end
    endtask

    task automatic test_reset_mid();
        fill_text("x");
        set_pat("HOLA");
        place(2, "HOLA");
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrst_status got %b/%b exp 0/0", busy, done); end
        n_vec++; if (count !== 8'd0 || found !== 1'b0 || first_pos !== 8'd0) begin
            n_err++; $display("FAIL midrst_results got %0d/%b/%0d exp 0/0/0", count, found, first_pos); end
        n_vec++; if (pat_addr !== 3'd0 || txt_addr !== 8'd0) begin
            n_err++; $display("FAIL midrst_addr got %0d/%0d exp 0/0", pat_addr, txt_addr); end
        @(negedge clk);
        rst = 1'b1;
        fill_text("x");
        place(30, "HOLA");
        model_search();
        run_search(0);
        n_vec++; if (obs_count !== CW'(exp_count) || obs_fpos !== 8'd30) begin
            n_err++; $display("FAIL midrst_rerun got %0d/%0d exp %0d/30", obs_count, obs_fpos, exp_count); end
        n_vec++; if (obs_edges != exp_lat) begin n_err++; $display("FAIL midrst_rerun_latency got %0d exp %0d", obs_edges, exp_lat); end
    endtask

    task automatic test_back_to_back();
        fill_text("x");
        set_pat("HOLA");
        place(10, "HOLA");
        run_search(0);
        fill_text("x");
        place(41, "HOLA");
        model_search();
        run_search(0);
        n_vec++; if (obs_count !== CW'(exp_count) || obs_fpos !== 8'd41) begin
            n_err++; $display("FAIL b2b_result got %0d/%0d exp %0d/41", obs_count, obs_fpos, exp_count); end
        n_vec++; if (obs_edges != exp_lat) begin n_err++; $display("FAIL b2b_latency got %0d exp %0d", obs_edges, exp_lat); end
    endtask

    initial begin
        for (int k = 0; k < (1<<PAW); k++) pat_mem[k] = 8'h00;
        fill_text("x");
        test_reset();
        test_hola();
        test_overlap();
        test_no_hit();
        test_last_alignment();
        test_random();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
